// File: rtl/flash_erase_pp_seq.sv
// flash_erase_pp_seq: one-shot WREN/SE/poll/WREN/PP/poll SPI-flash sequencer with a mode-0 bit engine (sck = clk/4)
module flash_erase_pp_seq #(
  parameter logic [23:0] SECTOR_ADDR = 24'h00_0000,
  parameter logic [23:0] PP_ADDR     = 24'h00_0000,
  parameter logic [8:0]  PP_LEN      = 9'd10,
  parameter logic [7:0]  DATA_INIT   = 8'h00,
  parameter logic [7:0]  CS_GAP      = 8'd32,
  parameter logic [23:0] POLL_MAX    = 24'd5000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic start,
  input  logic miso,
  output logic cs_n,
  output logic sck,
  output logic mosi,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [3:0] {IDLE, WREN1, SE, POLL1, WREN2, PP, POLL2, DONE, ERR} state_t;
  typedef enum logic [1:0] {P_SETUP, P_BITS, P_HOLD, P_GAP} phase_t;
  state_t st, st_n;
  phase_t ph, ph_n;
  logic [7:0] tmr, rx, tx, cmd;
  logic [1:0] cnt;
  logic [2:0] bitn;
  logic [8:0] byten, nbytes;
  logic [23:0] pcnt, addr;
  logic polling, tmr_end, last_bit, gap_end;
  // every frame walks setup -> bits -> hold -> gap; the command state advances only at the end of the gap
  always_comb begin
    polling = st == POLL1 || st == POLL2;
    addr = st == SE ? SECTOR_ADDR : PP_ADDR;
    cmd = st == SE ? 8'hD8 : st == PP ? 8'h02 : polling ? 8'h05 : 8'h06;
    nbytes = st == SE ? 9'd4 : st == PP ? 9'd4 + PP_LEN : polling ? 9'd2 : 9'd1;
    tx = byten == 9'd0 ? cmd : polling ? 8'h00 : byten == 9'd1 ? addr[23:16] : byten == 9'd2 ? addr[15:8] :
         byten == 9'd3 ? addr[7:0] : DATA_INIT + byten[7:0] - 8'd4;
    tmr_end = tmr == (ph == P_GAP ? CS_GAP - 8'd1 : 8'd3);
    last_bit = ph == P_BITS && cnt == 2'd3 && bitn == 3'd7 && byten == nbytes - 9'd1;
    gap_end = ph == P_GAP && tmr_end;
    ph_n = busy && ((ph != P_BITS && tmr_end) || last_bit) ? phase_t'(ph + 2'd1) : ph;
    st_n = st;
    case (st)
      IDLE:         st_n = start ? WREN1 : IDLE;
      POLL1, POLL2: st_n = !gap_end ? st : !rx[0] ? state_t'(st + 4'd1) : pcnt >= POLL_MAX - 24'd1 ? ERR : st;
      DONE, ERR:    st_n = IDLE;
      default:      st_n = gap_end ? state_t'(st + 4'd1) : st;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      st <= IDLE;
      ph <= P_SETUP;
      tmr <= 8'd0;
      cnt <= 2'd0;
      {byten, bitn} <= 12'd0;
      rx <= 8'd0;
      pcnt <= 24'd0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      tmr <= ph_n != ph || ph == P_BITS || !busy ? 8'd0 : tmr + 8'd1;
      cnt <= ph == P_BITS ? cnt + 2'd1 : 2'd0;
      {byten, bitn} <= ph != P_BITS ? 12'd0 : cnt == 2'd3 ? {byten, bitn} + 12'd1 : {byten, bitn};
      rx <= ph == P_BITS && cnt == 2'd2 ? {rx[6:0], miso} : rx;
      pcnt <= st_n != st ? 24'd0 : gap_end && polling ? pcnt + 24'd1 : pcnt;
    end
  assign busy = st != IDLE && st != DONE && st != ERR;
  assign cs_n = !(busy && ph != P_GAP);
  assign sck  = ph == P_BITS && cnt[1];
  assign mosi = ph == P_BITS && tx[~bitn];
  assign done = st == DONE;
  assign err  = st == ERR;
endmodule

// File: tb/tb_flash_erase_pp_seq.sv
// tb_flash_erase_pp_seq: frame-level flash model and scoreboard for flash_erase_pp_seq
module tb_flash_erase_pp_seq;
  localparam logic [23:0] SA = 24'hA53C96;
  localparam logic [23:0] PA = 24'h1234F0;
  localparam int LEN = 10;
  localparam logic [7:0] DI = 8'hFB;
  localparam int GAP = 32;
  localparam int PMAX = 4;
  logic sys_clk = 0, sys_rst_n = 0, start = 0, miso = 0;
  logic cs_n, sck, mosi, busy, done, err;
  int checks = 0, fails = 0;
  logic [7:0] got_b[$], exp_b[$];
  int got_l[$], exp_l[$];
  bit exp_err = 0, rnd_stat = 0;
  int fl_n1 = 0, fl_n2 = 0, wip_left = 0;
  logic ps = 0, pc = 1, pm = 0, in_gap = 0;
  logic [7:0] cur = 0, first = 0, stat = 0;
  int bits = 0, since = 0, gap = 0, min_gap = 1 << 30;
  int bad_period = 0, bad_stable = 0, bad_bits = 0, bad_idle = 0;
  int done_cnt = 0, err_cnt = 0, done_busy = 0;

  flash_erase_pp_seq #(.SECTOR_ADDR(SA), .PP_ADDR(PA), .PP_LEN(9'(LEN)), .DATA_INIT(DI),
                       .CS_GAP(8'(GAP)), .POLL_MAX(24'(PMAX))) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .miso(miso),
    .cs_n(cs_n), .sck(sck), .mosi(mosi), .busy(busy), .done(done), .err(err));

  always #10 sys_clk = ~sys_clk;

  // pin monitor and flash model: captures MOSI bytes per frame, answers RDSR with WIP from a busy-poll budget
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      bits = 0; in_gap = 0; first = 8'h00; miso = 1'b0;
    end else begin
      if (pc && !cs_n) begin
        if (in_gap && gap < min_gap) min_gap = gap;
        in_gap = 0; bits = 0; since = 0; first = 8'h00;
      end
      if (cs_n && sck) bad_idle++;
      if (!cs_n) begin
        since++;
        if (sck && !ps) begin
          if (bits > 0 && since != 4) bad_period++;
          if (mosi !== pm) bad_stable++;
          since = 0; cur = {cur[6:0], mosi}; bits++;
          if (bits % 8 == 0) got_b.push_back(cur);
          if (bits == 8) begin
            first = cur;
            stat = rnd_stat ? {7'($urandom), wip_left > 0} : (wip_left > 0 ? 8'h03 : 8'h00);
          end
        end else if (sck && mosi !== pm) bad_stable++;
        else if (!sck && ps && first == 8'h05 && bits >= 8 && bits < 16) miso = stat[3'(15 - bits)];
      end
      if (!pc && cs_n) begin
        got_l.push_back(bits / 8);
        if (bits % 8 != 0 || bits == 0) bad_bits++;
        if (first == 8'h05 && wip_left > 0) wip_left--;
        if (first == 8'hD8) wip_left = fl_n1;
        if (first == 8'h02) wip_left = fl_n2;
        in_gap = 1; gap = 0; miso = 1'b0;
      end
      if (cs_n && in_gap) gap++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((done || err) && busy) done_busy++;
    end
    ps = sck; pc = cs_n; pm = mosi;
  end

  // reference: expected MOSI bytes and frame sizes for n1/n2 busy polls after SE/PP
  task automatic model(input int n1, input int n2);
    logic [23:0] a;
    exp_b = {}; exp_l = {}; exp_err = 0;
    exp_b.push_back(8'h06); exp_l.push_back(1);
    a = SA;
    exp_b.push_back(8'hD8); exp_b.push_back(a[23:16]); exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]); exp_l.push_back(4);
    for (int i = 0; i < (n1 < PMAX ? n1 + 1 : PMAX); i++) begin exp_b.push_back(8'h05); exp_b.push_back(8'h00); exp_l.push_back(2); end
    if (n1 >= PMAX) begin exp_err = 1; return; end
    exp_b.push_back(8'h06); exp_l.push_back(1);
    a = PA;
    exp_b.push_back(8'h02); exp_b.push_back(a[23:16]); exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]);
    for (int k = 0; k < LEN; k++) exp_b.push_back(8'((int'(DI) + k) % 256));
    exp_l.push_back(4 + LEN);
    for (int i = 0; i < (n2 < PMAX ? n2 + 1 : PMAX); i++) begin exp_b.push_back(8'h05); exp_b.push_back(8'h00); exp_l.push_back(2); end
    exp_err = n2 >= PMAX;
  endtask

  function automatic int byte_diff();
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) if (got_b[i] !== exp_b[i]) return i;
    return got_b.size() == exp_b.size() ? -1 : (got_b.size() < exp_b.size() ? got_b.size() : exp_b.size());
  endfunction
  function automatic int len_diff();
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) if (got_l[i] != exp_l[i]) return i;
    return got_l.size() == exp_l.size() ? -1 : (got_l.size() < exp_l.size() ? got_l.size() : exp_l.size());
  endfunction
  function automatic logic [7:0] gb(input int i); return i >= 0 && i < got_b.size() ? got_b[i] : 8'hxx; endfunction
  function automatic logic [7:0] eb(input int i); return i >= 0 && i < exp_b.size() ? exp_b[i] : 8'hxx; endfunction

  task automatic tick(input int n); repeat (n) @(negedge sys_clk); endtask
  task automatic pulse(); start = 1; tick(1); start = 0; endtask
  task automatic launch(input int n1, input int n2);
    model(n1, n2); fl_n1 = n1; fl_n2 = n2;
    got_b = {}; got_l = {}; done_cnt = 0; err_cnt = 0; done_busy = 0;
    pulse();
  endtask
  task automatic wait_end(input bit poke, output bit to);
    int n = 0;
    while (!done && !err && n < 20000) begin tick(1); n++; end
    to = !(done || err);
    if (poke && !to) begin start = 1; tick(1); start = 0; end
    tick(60);
  endtask
  task automatic wait_bytes(input int n, output bit to);
    int k = 0;
    while (got_b.size() < n && k < 20000) begin tick(1); k++; end
    to = got_b.size() < n;
  endtask

  task automatic test_reset();
    tick(10);
    checks++; if (cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n got %b required 1", cs_n); end
    checks++; if (sck !== 1'b0) begin fails++; $display("FAIL reset_sck got %b required 0", sck); end
    checks++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got %b required 0", mosi); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b required 0", done); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b required 0", err); end
    sys_rst_n = 1; tick(2);
  endtask

  task automatic test_happy_path();
    bit to; int d;
    rnd_stat = 0;
    launch(2, 0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL happy_busy_rise got %b required 1", busy); end
    wait_end(0, to);
    checks++; if (to) begin fails++; $display("FAIL happy_end got timeout required done"); end
    d = byte_diff();
    checks++; if (d != -1) begin fails++; $display("FAIL happy_stream byte %0d got %h required %h (%0d/%0d bytes)", d, gb(d), eb(d), got_b.size(), exp_b.size()); end
    d = len_diff();
    checks++; if (d != -1) begin fails++; $display("FAIL happy_frames frame %0d got %0d frames required %0d", d, got_l.size(), exp_l.size()); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL happy_done got %0d pulses required 1", done_cnt); end
    checks++; if (err_cnt != 0) begin fails++; $display("FAIL happy_err got %0d pulses required 0", err_cnt); end
    checks++; if (done_busy != 0) begin fails++; $display("FAIL happy_busy_at_done got %0d required 0", done_busy); end
  endtask

  task automatic test_busy_lock();
    bit to; int d;
    rnd_stat = 0;
    launch(2, 0);
    wait_bytes(2, to);
    checks++; if (to) begin fails++; $display("FAIL lock_se got %0d bytes required 2", got_b.size()); end
    pulse();
    wait_bytes(18, to);
    checks++; if (to) begin fails++; $display("FAIL lock_pp got %0d bytes required 18", got_b.size()); end
    pulse();
    wait_end(1, to);
    checks++; if (to) begin fails++; $display("FAIL lock_end got timeout required done"); end
    d = byte_diff();
    checks++; if (d != -1) begin fails++; $display("FAIL lock_stream byte %0d got %h required %h (%0d/%0d bytes)", d, gb(d), eb(d), got_b.size(), exp_b.size()); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL lock_done got %0d pulses required 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL lock_idle_after_done got busy=%b required 0", busy); end
  endtask

  task automatic test_timeout();
    bit to; int d;
    rnd_stat = 0;
    launch(1000, 0);
    wait_end(0, to);
    checks++; if (to) begin fails++; $display("FAIL timeout_end got timeout required err"); end
    d = byte_diff();
    checks++; if (d != -1) begin fails++; $display("FAIL timeout_stream byte %0d got %h required %h (%0d/%0d bytes)", d, gb(d), eb(d), got_b.size(), exp_b.size()); end
    checks++; if (err_cnt != 1) begin fails++; $display("FAIL timeout_err got %0d pulses required 1", err_cnt); end
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL timeout_done got %0d pulses required 0", done_cnt); end
    checks++; if (done_busy != 0) begin fails++; $display("FAIL timeout_busy_at_err got %0d required 0", done_busy); end
    launch(0, 0);
    wait_end(0, to);
    d = byte_diff();
    checks++; if (to || d != -1) begin fails++; $display("FAIL timeout_restart byte %0d got %h required %h (to=%0b)", d, gb(d), eb(d), to); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL timeout_restart_done got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_pp();
    bit to; int d;
    rnd_stat = 0;
    launch(1, 0);
    wait_bytes(17, to);
    checks++; if (to) begin fails++; $display("FAIL midrst_reach got %0d bytes required 17", got_b.size()); end
    sys_rst_n = 0; #1;
    checks++; if (cs_n !== 1'b1) begin fails++; $display("FAIL midrst_cs_n got %b required 1", cs_n); end
    checks++; if (sck !== 1'b0) begin fails++; $display("FAIL midrst_sck got %b required 0", sck); end
    checks++; if (mosi !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_mosi_busy got %b%b required 00", mosi, busy); end
    tick(5); sys_rst_n = 1; tick(3);
    launch(2, 0);
    wait_end(0, to);
    d = byte_diff();
    checks++; if (to || d != -1) begin fails++; $display("FAIL midrst_rerun byte %0d got %h required %h (to=%0b)", d, gb(d), eb(d), to); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL midrst_done got %0d required 1", done_cnt); end
  endtask

  task automatic test_random();
    bit to; int d, n1, n2;
    rnd_stat = 1;
    for (int it = 0; it < 6; it++) begin
      n1 = $urandom_range(0, 5); n2 = $urandom_range(0, 5);
      tick($urandom_range(0, 20));
      launch(n1, n2);
      wait_end(1'($urandom_range(0, 1)), to);
      d = byte_diff();
      checks++; if (to || d != -1) begin fails++; $display("FAIL rand_stream n1=%0d n2=%0d byte %0d got %h required %h (to=%0b)", n1, n2, d, gb(d), eb(d), to); end
      checks++; if (done_cnt != int'(!exp_err) || err_cnt != int'(exp_err)) begin
        fails++; $display("FAIL rand_end n1=%0d n2=%0d got done=%0d err=%0d required done=%0d err=%0d", n1, n2, done_cnt, err_cnt, !exp_err, exp_err);
      end
    end
  endtask

  task automatic test_timing();
    checks++; if (bad_period != 0) begin fails++; $display("FAIL timing_period got %0d bad sck periods required 0", bad_period); end
    checks++; if (bad_stable != 0) begin fails++; $display("FAIL timing_mosi_stable got %0d violations required 0", bad_stable); end
    checks++; if (bad_bits != 0) begin fails++; $display("FAIL timing_frame_bits got %0d bad frames required 0", bad_bits); end
    checks++; if (bad_idle != 0) begin fails++; $display("FAIL timing_sck_idle got %0d samples required 0", bad_idle); end
    checks++; if (min_gap < GAP || min_gap == (1 << 30)) begin fails++; $display("FAIL timing_cs_gap got %0d required >=%0d", min_gap, GAP); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_busy_lock();
    test_timeout();
    test_reset_mid_pp();
    test_random();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
